// File: rtl/b01_pkg.sv
// Shared types and default sizes for the b01 serial-result collector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package b01_pkg;

  localparam int B01_WORD_W     = 8;
  localparam int B01_FIFO_DEPTH = 4;
  localparam int B01_CNT_W      = 8;

  // Packer state: IDLE holds no bits, FILL holds 1..WIDTH-1 bits.
  typedef enum logic {
    PK_IDLE = 1'b0,
    PK_FILL = 1'b1
  } pk_state_t;

endpackage

// File: rtl/b01_fifo.sv
// Show-ahead FIFO; head_data always presents the oldest entry.
// Latency: a push is visible at the head one cycle after the writing edge (no bypass).
// Backpressure: push is taken when not full, or when full and popped in the same cycle.
module b01_fifo #(
  parameter  int DATA_W = 9,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              full,
  output logic              empty,
  output logic [PTR_W:0]    count
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);
  assign rd_en     = pop && !empty;
  // When full, a same-cycle pop frees the slot the write pointer is aiming at.
  assign wr_en     = push && (!full || rd_en);
  assign head_data = mem[rd_ptr];

  // Storage, pointers and occupancy; storage is cleared so the head is never X.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/b01_collector.sv
// Packs qualified b01 outp bits LSB-first into words with a sticky overflow tag, queued to a valid/ready port.
// Latency: the edge sampling the last bit writes the FIFO; out_valid rises the following cycle.
// Backpressure: out_ready stalls the FIFO; a word completing into a full, unpopped FIFO is dropped and counted.
import b01_pkg::*;

module b01_collector #(
  parameter int WIDTH = B01_WORD_W,
  parameter int DEPTH = B01_FIFO_DEPTH,
  parameter int CNT_W = B01_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             outp,
  input  logic             overflw,
  input  logic             in_en,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             busy
);

  localparam int               BC_W     = $clog2(WIDTH);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WIDTH - 1);
  localparam logic [BC_W-1:0]  BC_ONE   = BC_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  pk_state_t        state;
  logic [BC_W-1:0]  bitcnt;
  logic [WIDTH-2:0] held_bits;
  logic             sticky;

  logic             sample;
  logic             word_done;
  logic             pop;
  logic             push_ok;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH:0]   push_entry;
  logic [WIDTH:0]   head_entry;
  logic [$clog2(DEPTH):0] unused_fifo_count;

  assign sample    = in_en && !flush;
  assign word_done = sample && (bitcnt == LAST_BIT);
  assign pop       = out_valid && out_ready;
  assign push_ok   = word_done && (!fifo_full || pop);

  // Completed word: held bits plus the bit arriving now as the MSB; flag folds in the current overflw.
  assign push_entry = {sticky | overflw, outp, held_bits};

  assign out_valid = !fifo_empty;
  assign out_ovf   = head_entry[WIDTH];
  assign out_data  = head_entry[WIDTH-1:0];
  assign busy      = (state == PK_FILL);

  b01_fifo #(
    .DATA_W (WIDTH + 1),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_ok),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (unused_fifo_count)
  );

  // Packer FSM: accumulate bits, hand off on the last one, and restart on flush.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= PK_IDLE;
      bitcnt    <= '0;
      held_bits <= '0;
      sticky    <= 1'b0;
    end else if (flush) begin
      state  <= PK_IDLE;
      bitcnt <= '0;
      sticky <= 1'b0;
    end else if (in_en) begin
      unique case (state)
        PK_IDLE: begin
          held_bits[bitcnt] <= outp;
          bitcnt            <= bitcnt + BC_ONE;
          sticky            <= overflw;
          state             <= PK_FILL;
        end
        PK_FILL: begin
          if (bitcnt == LAST_BIT) begin
            bitcnt <= '0;
            sticky <= 1'b0;
            state  <= PK_IDLE;
          end else begin
            held_bits[bitcnt] <= outp;
            bitcnt            <= bitcnt + BC_ONE;
            sticky            <= sticky | overflw;
          end
        end
        default: state <= PK_IDLE;
      endcase
    end
  end

  // Saturating statistics: sampled overflow cycles and words lost to a full FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_count  <= '0;
      drop_count <= '0;
    end else begin
      if (sample && overflw && (ovf_count != CNT_MAX)) begin
        ovf_count <= ovf_count + CNT_ONE;
      end
      if (word_done && !push_ok && (drop_count != CNT_MAX)) begin
        drop_count <= drop_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_b01_collector.sv
// Directed and random checks of b01_collector against a queue-based reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_b01_collector;

  localparam int W    = 8;
  localparam int D    = 4;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          outp = 1'b0;
  logic          overflw = 1'b0;
  logic          in_en = 1'b0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_ovf;
  logic [CW-1:0] ovf_count;
  logic [CW-1:0] drop_count;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Reference model: held bits, sticky flag, FIFO of {ovf, word}, counters.
  logic       mbits[$];
  logic       msticky;
  logic [W:0] mq[$];
  int         movf;
  int         mdrop;

  b01_collector #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clock      (clock),
    .reset      (reset),
    .outp       (outp),
    .overflw    (overflw),
    .in_en      (in_en),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ovf    (out_ovf),
    .ovf_count  (ovf_count),
    .drop_count (drop_count),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mbits.delete();
    mq.delete();
    msticky = 1'b0;
    movf    = 0;
    mdrop   = 0;
  endtask

  task automatic model_step(input logic en, input logic fl, input logic o,
                            input logic ov, input logic rdy);
    logic       do_pop;
    logic       do_push;
    logic [W:0] entry;
    do_pop  = (mq.size() > 0) && rdy;
    do_push = 1'b0;
    entry   = '0;
    if (fl) begin
      mbits.delete();
      msticky = 1'b0;
    end else if (en) begin
      mbits.push_back(o);
      msticky = msticky | ov;
      if (ov && movf < CMAX) movf++;
      if (mbits.size() == W) begin
        foreach (mbits[i]) entry[i] = mbits[i];
        entry[W] = msticky;
        mbits.delete();
        msticky = 1'b0;
        if (mq.size() < D || do_pop) do_push = 1'b1;
        else if (mdrop < CMAX) mdrop++;
      end
    end
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(entry);
  endtask

  task automatic compare_all();
    logic [W:0] head;
    check("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      head = mq[0];
      check("out_data", 32'(out_data), 32'(head[W-1:0]));
      check("out_ovf", 32'(out_ovf), 32'(head[W]));
    end
    check("ovf_count", 32'(ovf_count), 32'(movf));
    check("drop_count", 32'(drop_count), 32'(mdrop));
    check("busy", 32'(busy), 32'(mbits.size() != 0));
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it.
  task automatic cycle(input logic en, input logic fl, input logic o,
                       input logic ov, input logic rdy);
    in_en = en; flush = fl; outp = o; overflw = ov; out_ready = rdy;
    @(posedge clock);
    model_step(en, fl, o, ov, rdy);
    #1;
    compare_all();
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    in_en = 1'b0; flush = 1'b0; outp = 1'b0; overflw = 1'b0; out_ready = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_clear();
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data"}, 32'(out_data), 32'd0);
    check({tag, "_ovf"}, 32'(out_ovf), 32'd0);
    check({tag, "_ovfcnt"}, 32'(ovf_count), 32'd0);
    check({tag, "_dropcnt"}, 32'(drop_count), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic ov_last,
                           input logic rdy_rest, input logic rdy_last);
    for (int i = 0; i < W; i++) begin
      cycle(1'b1, 1'b0, w[i], (i == W - 1) ? ov_last : 1'b0,
            (i == W - 1) ? rdy_last : rdy_rest);
    end
  endtask

  task automatic pop_expect(input string tag, input logic [W-1:0] exp);
    check(tag, 32'(out_data), 32'(exp));
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [W-1:0] w;

    // Reset state.
    do_reset("rst0");

    // Plain word 1,0,1,1,0,0,1,0 -> 0x4D.
    send_word(8'h4D, 1'b0, 1'b0, 1'b0);
    check("w1_valid", 32'(out_valid), 32'd1);
    check("w1_data", 32'(out_data), 32'h4D);
    check("w1_ovf", 32'(out_ovf), 32'd0);
    check("w1_ovfcnt", 32'(ovf_count), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("w1_empty", 32'(out_valid), 32'd0);

    // Same word, gaps between samples with overflw=1 that must be ignored.
    w = 8'h4D;
    for (int i = 0; i < W; i++) begin
      cycle(1'b1, 1'b0, w[i], (i == W - 1) ? 1'b1 : 1'b0, 1'b0);
      if (i < W - 1) check("w2_busy", 32'(busy), 32'd1);
      cycle(1'b0, 1'b0, 1'($urandom), 1'b1, 1'b0);
      if (i < W - 1) check("w2_busy_gap", 32'(busy), 32'd1);
    end
    check("w2_data", 32'(out_data), 32'h4D);
    check("w2_ovf", 32'(out_ovf), 32'd1);
    check("w2_ovfcnt", 32'(ovf_count), 32'd1);
    check("w2_idle", 32'(busy), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Overfill: five words into four slots, one drop, then drain in order.
    for (int k = 1; k <= 5; k++) send_word(8'(k), 1'b0, 1'b0, 1'b0);
    check("ovr_drop", 32'(drop_count), 32'd1);
    pop_expect("ovr_h1", 8'h01);
    pop_expect("ovr_h2", 8'h02);
    pop_expect("ovr_h3", 8'h03);
    pop_expect("ovr_h4", 8'h04);
    check("ovr_empty", 32'(out_valid), 32'd0);

    // Full FIFO with a word completing on a pop cycle: no drop.
    for (int k = 0; k < D; k++) send_word(8'(8'h11 + k), 1'b0, 1'b0, 1'b0);
    send_word(8'h55, 1'b0, 1'b0, 1'b1);
    check("fp_drop", 32'(drop_count), 32'd1);
    pop_expect("fp_h1", 8'h12);
    pop_expect("fp_h2", 8'h13);
    pop_expect("fp_h3", 8'h14);
    pop_expect("fp_h4", 8'h55);
    check("fp_empty", 32'(out_valid), 32'd0);

    // Flush after 5 bits, with in_en high on the flush cycle.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("fl_busy", 32'(busy), 32'd0);
    check("fl_valid", 32'(out_valid), 32'd0);
    send_word(8'hA6, 1'b0, 1'b0, 1'b0);
    check("fl_data", 32'(out_data), 32'hA6);
    check("fl_ovf", 32'(out_ovf), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset with 3 entries queued and a 4-bit partial word.
    for (int k = 0; k < 3; k++) send_word(8'(8'hC0 + k), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    do_reset("rst1");

    // Overflow counter saturation.
    for (int i = 0; i < 260; i++) cycle(1'b1, 1'b0, 1'($urandom), 1'b1, 1'b1);
    check("ovf_sat", 32'(ovf_count), 32'd255);

    // Drop counter saturation: 260 words against a stalled consumer.
    for (int k = 0; k < 260; k++) send_word(8'($urandom), 1'b0, 1'b0, 1'b0);
    check("drop_sat", 32'(drop_count), 32'd255);

    // Random traffic against the model.
    do_reset("rst2");
    for (int i = 0; i < 1500; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0),
            1'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
